// File: rtl/irq_entry_ctrl.sv
// Interrupt entry controller: latches IRQ rising edges, drains the pipeline, then strobes a vectored entry.
// Optional build macro IRQ_ENTRY_MASK_REG_EN adds a software-writable IRQ mask register.
module irq_entry_ctrl #(
   parameter int          IRQ_NUM      = 8,
   parameter logic [31:0] VECTOR_BASE  = 32'h0000_0100,
   parameter int          VECTOR_SHIFT = 2,
   parameter int          IE_BIT       = 0
) (
   input  logic               clk,
   input  logic               all_rst,
   input  logic [IRQ_NUM-1:0] irq_in,
   input  logic [31:0]        sys,
   input  logic [31:0]        resume_pc,
   input  logic               pipe_empty,
`ifdef IRQ_ENTRY_MASK_REG_EN
   input  logic               mask_wr,
   input  logic [IRQ_NUM-1:0] mask_wdata,
`endif
   output logic               pipe_drain_req,
   output logic               interrupt_ask,
   output logic [31:0]        interrupt_pc,
   output logic [31:0]        interrupt_ipc,
   output logic [7:0]         interrupt_num,
   output logic [IRQ_NUM-1:0] irq_pending,
   output logic               busy
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRAIN,
      ST_ENTER,
      ST_SETTLE
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [IRQ_NUM-1:0]  r_irq_prev;
   logic [IRQ_NUM-1:0]  r_pending;
   logic [IRQ_NUM-1:0]  w_rise;
   logic [IRQ_NUM-1:0]  w_mask;
   logic [IRQ_NUM-1:0]  w_req;
   logic [IRQ_NUM-1:0]  w_clr;
   logic [7:0]          w_pick;
   logic [7:0]          r_sel;
   logic [7:0]          w_sel_nxt;
   logic                r_drain;
   logic                w_drain_nxt;
   logic                r_ask;
   logic                w_ask_nxt;
   logic [31:0]         r_pc;
   logic [31:0]         w_pc_nxt;
   logic [31:0]         r_ipc;
   logic [31:0]         w_ipc_nxt;
   logic [7:0]          r_num;
   logic [7:0]          w_num_nxt;
   logic [31:0]         w_vector;
   logic                w_ie;
   logic                w_unused;

`ifdef IRQ_ENTRY_MASK_REG_EN
   logic [IRQ_NUM-1:0]  r_mask;

   always_ff @(posedge clk) begin
      if (all_rst) begin
         r_mask <= '1;
      end else if (mask_wr) begin
         r_mask <= mask_wdata;
      end
   end

   assign w_mask = r_mask;
`else
   assign w_mask = '1;
`endif

   assign w_ie     = sys[IE_BIT];
   assign w_rise   = irq_in & ~r_irq_prev;
   assign w_req    = r_pending & w_mask;
   assign w_vector = VECTOR_BASE + ({24'd0, r_sel} << VECTOR_SHIFT);
   assign w_unused = ^sys;

   // Lowest pending-and-unmasked index wins.
   always_comb begin
      w_pick = 8'd0;
      for (int i = IRQ_NUM - 1; i >= 0; i--) begin
         if (w_req[i]) begin
            w_pick = 8'(i);
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_drain_nxt = r_drain;
      w_ask_nxt   = 1'b0;
      w_pc_nxt    = r_pc;
      w_ipc_nxt   = r_ipc;
      w_num_nxt   = r_num;
      w_sel_nxt   = r_sel;
      w_clr       = '0;
      case (r_state)
         ST_IDLE: begin
            if ((|w_req) && w_ie) begin
               w_state_nxt = ST_DRAIN;
               w_drain_nxt = 1'b1;
               w_sel_nxt   = w_pick;
            end
         end
         ST_DRAIN: begin
            // Losing IE while draining abandons the entry; pending stays for later.
            if (!w_ie) begin
               w_state_nxt = ST_IDLE;
               w_drain_nxt = 1'b0;
            end else if (pipe_empty) begin
               w_state_nxt = ST_ENTER;
               w_ask_nxt   = 1'b1;
               w_pc_nxt    = w_vector;
               w_ipc_nxt   = resume_pc;
               w_num_nxt   = r_sel;
               w_clr       = IRQ_NUM'(1) << r_sel;
            end
         end
         ST_ENTER: begin
            w_state_nxt = ST_SETTLE;
            w_drain_nxt = 1'b0;
         end
         ST_SETTLE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (all_rst) begin
         r_state    <= ST_IDLE;
         r_irq_prev <= '0;
         r_pending  <= '0;
         r_sel      <= 8'd0;
         r_drain    <= 1'b0;
         r_ask      <= 1'b0;
         r_pc       <= 32'd0;
         r_ipc      <= 32'd0;
         r_num      <= 8'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_irq_prev <= irq_in;
         // A fresh edge wins over a same-cycle service clear.
         r_pending  <= (r_pending & ~w_clr) | w_rise;
         r_sel      <= w_sel_nxt;
         r_drain    <= w_drain_nxt;
         r_ask      <= w_ask_nxt;
         r_pc       <= w_pc_nxt;
         r_ipc      <= w_ipc_nxt;
         r_num      <= w_num_nxt;
      end
   end

   assign pipe_drain_req = r_drain;
   assign interrupt_ask  = r_ask;
   assign interrupt_pc   = r_pc;
   assign interrupt_ipc  = r_ipc;
   assign interrupt_num  = r_num;
   assign irq_pending    = r_pending;
   assign busy           = (r_state != ST_IDLE);

endmodule

// File: tb/tb_irq_entry_ctrl.sv
// Bench for irq_entry_ctrl: directed scenarios with literal expectations plus a randomized run
// compared every cycle against a behavioural model of the entry protocol.
module tb_irq_entry_ctrl;

   logic        clk = 1'b0;
   logic        all_rst;
   logic [7:0]  irq_in;
   logic [31:0] sys;
   logic [31:0] resume_pc;
   logic        pipe_empty;
   logic        pipe_drain_req;
   logic        interrupt_ask;
   logic [31:0] interrupt_pc;
   logic [31:0] interrupt_ipc;
   logic [7:0]  interrupt_num;
   logic [7:0]  irq_pending;
   logic        busy;

   int n_vec = 0;
   int n_bad = 0;

   irq_entry_ctrl dut (
      .clk            (clk),
      .all_rst        (all_rst),
      .irq_in         (irq_in),
      .sys            (sys),
      .resume_pc      (resume_pc),
      .pipe_empty     (pipe_empty),
      .pipe_drain_req (pipe_drain_req),
      .interrupt_ask  (interrupt_ask),
      .interrupt_pc   (interrupt_pc),
      .interrupt_ipc  (interrupt_ipc),
      .interrupt_num  (interrupt_num),
      .irq_pending    (irq_pending),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   // Behavioural model: protocol phases tracked as "waiting for drain" and
   // "cycles remaining after the entry strobe".
   bit          m_ok = 0;
   bit [7:0]    m_prev, m_pend;
   bit          m_waiting;
   int          m_after;
   int          m_sel;
   bit          m_drain, m_ask;
   bit [31:0]   m_pc, m_ipc;
   bit [7:0]    m_num;

   function automatic int lowest(input bit [7:0] v);
      for (int i = 0; i < 8; i++) if (v[i]) return i;
      return 0;
   endfunction

   always @(posedge clk) begin
      bit [7:0] rise, clr;
      bit       ask;
      if (all_rst) begin
         m_ok = 1; m_prev = 0; m_pend = 0; m_waiting = 0; m_after = 0; m_sel = 0;
         m_drain = 0; m_ask = 0; m_pc = 0; m_ipc = 0; m_num = 0;
      end else begin
         rise = irq_in & ~m_prev;
         clr  = 0;
         ask  = 0;
         if (m_after == 2) begin
            m_drain = 0;
            m_after = 1;
         end else if (m_after == 1) begin
            m_after = 0;
         end else if (m_waiting) begin
            if (!sys[0]) begin
               m_waiting = 0;
               m_drain   = 0;
            end else if (pipe_empty) begin
               m_ipc = resume_pc;
               m_pc  = 32'h100 + 32'(m_sel) * 4;
               m_num = 8'(m_sel);
               ask   = 1;
               clr[m_sel] = 1'b1;
               m_waiting = 0;
               m_after   = 2;
            end
         end else if (m_pend != 0 && sys[0]) begin
            m_sel     = lowest(m_pend);
            m_waiting = 1;
            m_drain   = 1;
         end
         m_pend = (m_pend & ~clr) | rise;
         m_prev = irq_in;
         m_ask  = ask;
      end
   end

   always @(negedge clk) begin
      logic [89:0] act, exp;
      if (m_ok) begin
         act = {pipe_drain_req, interrupt_ask, interrupt_pc, interrupt_ipc, interrupt_num, irq_pending, busy};
         exp = {m_drain, m_ask, m_pc, m_ipc, m_num, m_pend, (m_waiting || m_after != 0)};
         n_vec++;
         if (act !== exp) begin
            n_bad++;
            $display("FAIL model_cmp t=%0t got %h expected %h", $time, act, exp);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit seen;
      all_rst = 1; irq_in = 0; sys = 0; resume_pc = 0; pipe_empty = 0;

      // Reset with toggling lines
      repeat (3) begin
         step();
         irq_in = ~irq_in;
      end
      irq_in = 0;
      step();
      chk("rst_drain", 32'(pipe_drain_req), 0);
      chk("rst_ask", 32'(interrupt_ask), 0);
      chk("rst_pend", 32'(irq_pending), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_pc", interrupt_pc, 0);
      all_rst = 0;
      step();

      // Single IRQ on line 3
      sys = 1; resume_pc = 32'h40; irq_in = 8'h08;
      step();
      chk("s_pend", 32'(irq_pending), 32'h08);
      chk("s_drain_t1", 32'(pipe_drain_req), 0);
      step();
      chk("s_drain_t2", 32'(pipe_drain_req), 1);
      chk("s_busy", 32'(busy), 1);
      step();
      chk("s_ask_t3", 32'(interrupt_ask), 0);
      step();
      pipe_empty = 1;
      step();
      chk("s_ask_t5", 32'(interrupt_ask), 1);
      chk("s_pc", interrupt_pc, 32'h10C);
      chk("s_ipc", interrupt_ipc, 32'h40);
      chk("s_num", 32'(interrupt_num), 3);
      chk("s_pend_clr", 32'(irq_pending), 0);
      chk("s_drain_t5", 32'(pipe_drain_req), 1);
      pipe_empty = 0; sys = 0;
      step();
      chk("s_ask_t6", 32'(interrupt_ask), 0);
      chk("s_drain_t6", 32'(pipe_drain_req), 0);
      chk("s_pc_hold", interrupt_pc, 32'h10C);
      step();
      chk("s_idle", 32'(busy), 0);
      irq_in = 0; sys = 1;
      step();

      // Simultaneous edges on lines 2 and 5
      irq_in = 8'h24;
      step();
      step();
      chk("m_drain", 32'(pipe_drain_req), 1);
      pipe_empty = 1;
      step();
      chk("m_pc2", interrupt_pc, 32'h108);
      chk("m_num2", 32'(interrupt_num), 2);
      chk("m_pend5", 32'(irq_pending), 32'h20);
      sys = 0; pipe_empty = 0;
      step();
      step();
      chk("m_stall", 32'(pipe_drain_req), 0);
      sys = 1;
      step();
      chk("m_drain5", 32'(pipe_drain_req), 1);
      pipe_empty = 1;
      step();
      chk("m_ask5", 32'(interrupt_ask), 1);
      chk("m_pc5", interrupt_pc, 32'h114);
      chk("m_pend0", 32'(irq_pending), 0);
      pipe_empty = 0; sys = 0; irq_in = 0;
      step();
      step();

      // Disabled: edge latched, no drain until IE set
      irq_in = 8'h01;
      step();
      chk("d_pend", 32'(irq_pending), 32'h01);
      seen = 0;
      repeat (20) begin
         step();
         seen |= pipe_drain_req;
      end
      chk("d_hold", 32'(seen), 0);
      sys = 1;
      step();
      chk("d_drain", 32'(pipe_drain_req), 1);
      pipe_empty = 1;
      step();
      chk("d_pc", interrupt_pc, 32'h100);
      chk("d_num", 32'(interrupt_num), 0);
      pipe_empty = 0; sys = 0; irq_in = 0;
      step();
      step();

      // Abort in drain, then re-set on the serviced line at the clear edge
      sys = 1; irq_in = 8'h02;
      step();
      irq_in = 0;
      step();
      chk("a_drain", 32'(pipe_drain_req), 1);
      sys = 0;
      step();
      chk("a_drain_off", 32'(pipe_drain_req), 0);
      chk("a_ask", 32'(interrupt_ask), 0);
      chk("a_pend", 32'(irq_pending), 32'h02);
      chk("a_busy", 32'(busy), 0);
      sys = 1;
      step();
      chk("a_redrain", 32'(pipe_drain_req), 1);
      pipe_empty = 1; irq_in = 8'h02;
      step();
      chk("a_ask1", 32'(interrupt_ask), 1);
      chk("a_num1", 32'(interrupt_num), 1);
      chk("a_reset_pend", 32'(irq_pending), 32'h02);
      pipe_empty = 0; sys = 0; irq_in = 0;
      step();
      step();

      // Reset during drain
      sys = 1;
      step();
      chk("r_drain", 32'(pipe_drain_req), 1);
      all_rst = 1;
      step();
      chk("r_busy", 32'(busy), 0);
      chk("r_drain0", 32'(pipe_drain_req), 0);
      chk("r_pend0", 32'(irq_pending), 0);
      all_rst = 0;
      step();

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < 8; b++) if ($urandom_range(0, 7) == 0) irq_in[b] = ~irq_in[b];
         sys        = ($urandom() & 32'hFFFF_FFFE) | 32'($urandom_range(0, 9) != 0);
         pipe_empty = ($urandom_range(0, 2) == 0);
         resume_pc  = $urandom();
         all_rst    = ($urandom_range(0, 199) == 0);
         step();
      end
      all_rst = 0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
